// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// IMEM_LOADER_CSUM_EN enables the trailing checksum-byte check.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH     = 64;
  localparam int unsigned IMEM_ADDR_W    = 6;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned NUM_W          = IMEM_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    CHECK = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                   in_valid;
  logic [BYTE_W-1:0]      in_data;
  logic                   in_ready;
  logic                   imem_we;
  logic [IMEM_ADDR_W-1:0] imem_waddr;
  logic [WORD_W-1:0]      imem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; flags the completing byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic [BYTE_W-1:0] data,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [BCNT_W-1:0] byte_cnt_q;
  logic [WORD_W-1:0] lane_q;

  // Merge the incoming byte into its lane so the full word is visible on the 4th byte
  always_comb begin
    word_c = lane_q;
    word_c[{byte_cnt_q, 3'b000} +: BYTE_W] = data;
    word_valid_c = en && (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      byte_cnt_q <= '0;
      lane_q     <= '0;
    end else if (en) begin
      byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
      lane_q     <= word_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: streams bytes into the 64-word instruction memory while holding the core.
// IMEM_LOADER_CSUM_EN adds a CHECK state that verifies an XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num_words,
  input  logic             abort,
  imem_loader_if.master    bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_e                 state_q, state_n;
  logic [NUM_W-1:0]       num_q, num_n;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_n;
  logic [IMEM_ADDR_W-1:0] waddr_q, waddr_n;
  logic [WORD_W-1:0]      wdata_q, wdata_n;
  logic [BYTE_W-1:0]      csum_q, csum_n;
  logic                   rdy_q, rdy_n, we_q, we_n;
  logic                   hold_q, hold_n, busy_q, busy_n;
  logic                   done_q, done_n, err_q, err_n;

  logic              start_ok_c, byte_acc_c, pack_en_c, pack_clr_c;
  logic              last_word_c, wr_last_c, word_valid_c;
  logic [WORD_W-1:0] word_c;

  assign start_ok_c  = start && (num_words != '0) && (num_words <= NUM_W'(IMEM_DEPTH));
  assign byte_acc_c  = bus.in_valid && rdy_q && !abort;
  assign pack_en_c   = byte_acc_c && (state_q == LOAD);
  assign pack_clr_c  = rst || abort || ((state_q == IDLE) && start);
  assign last_word_c = (NUM_W'(addr_q) == num_q - NUM_W'(1));
  // The strobe for the final word is on the bus this cycle
  assign wr_last_c   = we_q && (NUM_W'(waddr_q) == num_q - NUM_W'(1));

  imem_word_packer u_packer (
    .clk          (clk),
    .clear        (pack_clr_c),
    .en           (pack_en_c),
    .data         (bus.in_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      num_q   <= num_n;
      addr_q  <= addr_n;
      waddr_q <= waddr_n;
      wdata_q <= wdata_n;
      csum_q  <= csum_n;
      rdy_q   <= rdy_n;
      we_q    <= we_n;
      hold_q  <= hold_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    num_n   = num_q;
    addr_n  = addr_q;
    waddr_n = waddr_q;
    wdata_n = wdata_q;
    csum_n  = csum_q;
    rdy_n   = 1'b0;
    we_n    = 1'b0;
    hold_n  = hold_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    err_n   = err_q;

    case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          state_n = LOAD;
          num_n   = num_words;
          addr_n  = '0;
          csum_n  = '0;
          err_n   = 1'b0;
          busy_n  = 1'b1;
          hold_n  = 1'b1;
          rdy_n   = 1'b1;
        end else if (start) begin
          err_n  = 1'b1;
          hold_n = 1'b0;
        end
      end

      LOAD: begin
        if (abort) begin
          state_n = IDLE;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          hold_n  = 1'b0;
        end else begin
          if (pack_en_c) csum_n = csum_q ^ bus.in_data;
          if (word_valid_c) begin
            we_n    = 1'b1;
            waddr_n = addr_q;
            wdata_n = word_c;
            if (!last_word_c) addr_n = addr_q + IMEM_ADDR_W'(1);
          end
          // Finish only once the final write strobe has been issued
          if (wr_last_c) begin
            if (CSUM_EN) begin
              state_n = CHECK;
              rdy_n   = 1'b1;
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              hold_n  = 1'b0;
            end
          end else begin
            rdy_n = !(word_valid_c && last_word_c);
          end
        end
      end

      CHECK: begin
        if (abort) begin
          state_n = IDLE;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          hold_n  = 1'b0;
        end else if (byte_acc_c) begin
          busy_n = 1'b0;
          if (bus.in_data == csum_q) begin
            state_n = DONE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end else begin
          rdy_n = 1'b1;
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready   = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams are checked against an expected write list.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NUM_W-1:0] num_words = '0;
  logic             cpu_hold, busy, done, err;

  imem_loader_if bus();

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .abort     (abort),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int unsigned  wr_addr_q[$];
  int unsigned  wr_data_q[$];
  bit           wr_hold_q[$];
  int           done_cnt = 0;
  int           hold_bad = 0;
  byte unsigned stim_q[$];

  // Record every write strobe, done pulse and any busy cycle without the core held
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(32'(bus.imem_waddr));
      wr_data_q.push_back(bus.imem_wdata);
      wr_hold_q.push_back(cpu_hold);
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1 && cpu_hold !== 1'b1) hold_bad <= hold_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start(input int n);
    start     = 1'b1;
    num_words = NUM_W'(n);
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input byte unsigned b, input bit gaps);
    int budget;
    bit acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        tick();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    do begin
      acc = bus.in_ready;
      tick();
      budget++;
    end while (!acc && budget < 20);
    bus.in_valid = 1'b0;
    check("in_ready", 32'(acc), 32'd1);
  endtask

  task automatic fill_stim(input int n);
    stim_q.delete();
    for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
  endtask

  function automatic int unsigned model_word(input int i);
    return 32'(stim_q[4*i]) + 32'(stim_q[4*i+1]) * 256 +
           32'(stim_q[4*i+2]) * 65536 + 32'(stim_q[4*i+3]) * 16777216;
  endfunction

  // Full successful load of stim_q as n words; checks every write and the final status
  task automatic run_load(input int n, input bit gaps, input string tag);
    int wb, db, hb, w;
    byte unsigned x;
    wb = wr_addr_q.size();
    db = done_cnt;
    hb = hold_bad;
    send_start(n);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_err_clr"}, 32'(err), 32'd0);
    x = 8'h00;
    foreach (stim_q[i]) begin
      send_byte(stim_q[i], gaps);
      x ^= stim_q[i];
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(x, gaps);
`endif
    w = 0;
    while (done_cnt == db && w < 40) begin
      tick();
      w++;
    end
    repeat (2) tick();
    check({tag, "_nwr"}, 32'(wr_addr_q.size() - wb), 32'(n));
    for (int i = 0; i < n && wb + i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, wr_addr_q[wb+i], 32'(i));
      check({tag, "_data"}, wr_data_q[wb+i], model_word(i));
      check({tag, "_wr_hold"}, 32'(wr_hold_q[wb+i]), 32'd1);
    end
    check({tag, "_done"}, 32'(done_cnt - db), 32'd1);
    check({tag, "_hold_gap"}, 32'(hold_bad - hb), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_hold_rel"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_rdy_end"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, db;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Directed single word 0x00A00313
    stim_q.delete();
    stim_q.push_back(8'h13);
    stim_q.push_back(8'h03);
    stim_q.push_back(8'hA0);
    stim_q.push_back(8'h00);
    run_load(1, 1'b0, "w1");

    // Three words with random valid gaps
    fill_stim(3);
    run_load(3, 1'b1, "w3");

    // Illegal lengths: error, stay idle, no writes
    wb = wr_addr_q.size();
    send_start(0);
    check("len0_err", 32'(err), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_rdy", 32'(bus.in_ready), 32'd0);
    send_start(65);
    check("len65_err", 32'(err), 32'd1);
    check("len65_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("len_bad_nwr", 32'(wr_addr_q.size() - wb), 32'd0);
    fill_stim(2);
    run_load(2, 1'b1, "after_err");

    // Random lengths plus a full-depth load
    for (int t = 0; t < 6; t++) begin
      fill_stim(int'($urandom_range(1, 12)));
      run_load(stim_q.size() / 4, 1'b1, "rnd");
    end
    fill_stim(IMEM_DEPTH);
    run_load(IMEM_DEPTH, 1'b0, "full");

    // Abort two bytes into word 1; the byte offered with abort is dropped
    fill_stim(4);
    wb = wr_addr_q.size();
    db = done_cnt;
    send_start(4);
    for (int i = 0; i < 6; i++) send_byte(stim_q[i], 1'b1);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = stim_q[6];
    tick();
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_err", 32'(err), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hold", 32'(cpu_hold), 32'd0);
    check("abort_rdy", 32'(bus.in_ready), 32'd0);
    repeat (4) tick();
    check("abort_nwr", 32'(wr_addr_q.size() - wb), 32'd1);
    if (wr_addr_q.size() > wb) begin
      check("abort_addr", wr_addr_q[wb], 32'd0);
      check("abort_data", wr_data_q[wb], model_word(0));
    end
    check("abort_done", 32'(done_cnt - db), 32'd0);

    // Reset coincident with the 4th byte of a word cancels the write
    fill_stim(2);
    wb = wr_addr_q.size();
    send_start(2);
    for (int i = 0; i < 3; i++) send_byte(stim_q[i], 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = stim_q[3];
    rst          = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check_all_zero("rst_mid");
    repeat (3) tick();
    check("rst_mid_nwr", 32'(wr_addr_q.size() - wb), 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
    // Wrong checksum: error, no done, core stays held
    stim_q.delete();
    stim_q.push_back(8'h13);
    stim_q.push_back(8'h03);
    stim_q.push_back(8'hA0);
    stim_q.push_back(8'h00);
    wb = wr_addr_q.size();
    db = done_cnt;
    send_start(1);
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (4) tick();
    check("csum_bad_err", 32'(err), 32'd1);
    check("csum_bad_done", 32'(done_cnt - db), 32'd0);
    check("csum_bad_hold", 32'(cpu_hold), 32'd1);
    check("csum_bad_nwr", 32'(wr_addr_q.size() - wb), 32'd1);
    fill_stim(2);
    run_load(2, 1'b1, "csum_recover");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the 64 x 32-bit instruction memory. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. Each completed word is written through a one-cycle write strobe at sequential word addresses starting at 0. While loading, the block holds the core in reset; it releases the core and pulses done when the requested word count has been written.

Parameters:
DEPTH, 64, number of instruction words; the maximum load length.
ADDR_W, 6, word-address width; must equal clog2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  one-cycle request to begin a load; sampled only in IDLE.
num_words  input  7  words to load, 1..DEPTH; latched on an accepted start.
abort  input  1  cancels a load in progress.
in_valid  input  1  byte available on in_data.
in_data  input  8  stream byte.
in_ready  output  1  loader can accept a byte this cycle.
imem_we  output  1  instruction-memory write strobe, one cycle per word.
imem_waddr  output  ADDR_W  word address for the write.
imem_wdata  output  32  word to write.
cpu_hold  output  1  holds the core in reset while high.
busy  output  1  load in progress.
done  output  1  one-cycle pulse on successful completion.
err  output  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (synchronous, active-high; the entire state is affected only at a rising clk edge): state=IDLE; byte_cnt=0; word_addr=0; all outputs are 0, including in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done and err.
- States: IDLE, LOAD, DONE (plus CHECK when the optional feature is enabled).
- IDLE, start with 1<=num_words<=DEPTH:
  - Go to LOAD; latch num_words.
  - Clear word_addr, byte_cnt and err.
  - Set busy=1 and cpu_hold=1.
- IDLE, start with num_words=0 or num_words>DEPTH: stay in IDLE; err=1.
- LOAD:
  - in_ready=1.
  - A byte is accepted only when in_valid and in_ready are both high.
  - Byte k (k = byte_cnt, 0..3) goes to bits [8k+7:8k]; byte_cnt then increments and wraps 3 -> 0.
- Word write timing:
  - The 4th byte of a word is accepted in cycle N.
  - In cycle N+1: imem_we=1 with imem_waddr=word_addr and imem_wdata=the packed word.
  - word_addr increments at the same edge that registers the write.
  - in_ready stays high, so back-to-back words at one byte per cycle are legal.
- After the write of word num_words-1, go to DONE; no further bytes are accepted (in_ready=0).
- DONE lasts one cycle:
  - done=1, busy=0, cpu_hold=0.
  - The next state is IDLE.
- imem_waddr and imem_wdata hold their last values when imem_we=0.
- abort in LOAD takes priority over a byte accepted in the same cycle:
  - That byte is dropped; go to IDLE.
  - err=1, busy=0, cpu_hold=0, and no done pulse.
  - A partially packed word is discarded and never written.
- start while not in IDLE is ignored.
- abort in IDLE or DONE is ignored.
- rst asserted mid-load returns everything to reset values at the next edge; a pending write strobe is cancelled.
- word_addr never exceeds num_words-1, so no address wrap is possible.

Optional Feature:
Macro IMEM_LOADER_CSUM_EN.
- Defined:
  - After the last word is written, go to CHECK with in_ready=1.
  - Accept exactly one checksum byte.
  - If it equals the XOR of all data bytes: go to DONE as normal.
  - If it mismatches: err=1, no done pulse; cpu_hold stays 1 until the next start or rst.
  - abort in CHECK behaves as abort in LOAD.
- Undefined: no CHECK state; LOAD goes directly to DONE.

Decomposition:
- Package imem_loader_pkg:
  - State enum (IDLE, LOAD, DONE, CHECK).
  - IMEM_DEPTH=64, IMEM_ADDR_W=6, BYTES_PER_WORD=4.
- One sub-module, imem_word_packer:
  - Contains byte_cnt and the 32-bit shift/lane register.
  - Outputs word_valid (one cycle) and word.
  - Has a clear input driven by start, abort and rst.
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Start with num_words=1, then bytes 13,03,A0,00 on consecutive cycles -> one-cycle imem_we with waddr=0, wdata=0x00A00313; done pulses; cpu_hold falls.
- num_words=3, bytes streamed with in_valid randomly deasserted -> three writes at addresses 0,1,2 with correct words; cpu_hold=1 throughout until DONE.
- num_words=0, then num_words=65 -> err=1, state stays IDLE, imem_we never asserted; a following valid start clears err.
- Abort after 2 bytes of word 1 (num_words=4) -> exactly one write (addr 0), no write at addr 1, err=1, no done pulse.
- rst asserted in the same cycle as the 4th byte -> no imem_we; all outputs 0 the next cycle.
- With IMEM_LOADER_CSUM_EN: word 0x00A00313 plus checksum 0xB0 -> done pulses. Checksum 0x00 -> err=1, no done, cpu_hold stays 1.
